// File: rtl/exc_pkg.sv
// Shared types for the exception sequencer: CP0 type codes, FSM states,
// default handler offset and the EPC-from-PC helper.
package exc_pkg;

  typedef enum logic [2:0] {
    EXC_T_NONE   = 3'b000,
    EXC_T_ERET   = 3'b010,
    EXC_T_SYS    = 3'b100,
    EXC_T_SYS_DS = 3'b101,
    EXC_T_INT    = 3'b110,
    EXC_T_INT_DS = 3'b111
  } exc_type_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2
  } exc_state_e;

  localparam logic [31:0] EXC_OFFSET_DEFAULT = 32'h0000_0180;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_ds);
    return in_ds ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// 6-bit two-flop synchronizer for the raw external interrupt lines.
module int_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_async,
  output logic [5:0] o_sync
);

  logic [5:0] r_meta;
  logic [5:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer in front of CP0: IDLE -> COMMIT (cp0_we) -> REDIRECT (flush + fetch redirect).
// Interrupt support is compiled in only when EXC_CTRL_INT_EN is defined.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_OFFSET = EXC_OFFSET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_syscall,
  input  logic        mem_eret,
  input  logic        mem_in_ds,
  input  logic [5:0]  int_i,
  input  logic [31:0] cp0_ebase,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  output logic        cp0_we,
  output logic [2:0]  cp0_type,
  output logic [31:0] cp0_excaddr,
  output logic        busy,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc
);

  exc_state_e  r_state, w_state_nxt;
  exc_type_e   r_type, w_type_nxt;
  logic [31:0] r_excaddr, w_excaddr_nxt;
  logic        r_to_vector, w_to_vector_nxt;
  logic        w_int_pending;
  logic        w_event;
  logic        w_unused;

`ifdef EXC_CTRL_INT_EN
  logic [5:0] w_int_sync;

  int_sync u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (int_i),
    .o_sync  (w_int_sync)
  );

  assign w_int_pending = (|(w_int_sync & cp0_status[15:10])) & cp0_status[0] & ~cp0_status[1];
  assign w_unused      = ^{cp0_status[31:16], cp0_status[9:2]};
`else
  assign w_int_pending = 1'b0;
  assign w_unused      = ^{int_i, cp0_status};
`endif

  assign w_event = mem_valid & (w_int_pending | mem_syscall | mem_eret);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_type_nxt      = r_type;
    w_excaddr_nxt   = r_excaddr;
    w_to_vector_nxt = r_to_vector;
    case (r_state)
      S_IDLE: begin
        if (w_event) begin
          w_state_nxt = S_COMMIT;
          // Priority: interrupt, then syscall, then eret.
          if (w_int_pending) begin
            w_type_nxt      = mem_in_ds ? EXC_T_INT_DS : EXC_T_INT;
            w_excaddr_nxt   = epc_of(mem_pc, mem_in_ds);
            w_to_vector_nxt = 1'b1;
          end else if (mem_syscall) begin
            w_type_nxt      = mem_in_ds ? EXC_T_SYS_DS : EXC_T_SYS;
            w_excaddr_nxt   = epc_of(mem_pc, mem_in_ds);
            w_to_vector_nxt = 1'b1;
          end else begin
            w_type_nxt      = EXC_T_ERET;
            w_excaddr_nxt   = 32'h0;
            w_to_vector_nxt = 1'b0;
          end
        end
      end
      S_COMMIT:   w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_type      <= EXC_T_NONE;
      r_excaddr   <= 32'h0;
      r_to_vector <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_type      <= w_type_nxt;
      r_excaddr   <= w_excaddr_nxt;
      r_to_vector <= w_to_vector_nxt;
    end
  end

  assign cp0_we      = (r_state == S_COMMIT);
  assign cp0_type    = r_type;
  assign cp0_excaddr = r_excaddr;
  assign busy        = (r_state != S_IDLE) | w_event;
  assign flush       = (r_state == S_REDIRECT);
  assign redir_valid = (r_state == S_REDIRECT);
  // Target is read in REDIRECT so CP0 has already absorbed the commit.
  assign redir_pc    = (r_state != S_REDIRECT) ? 32'h0 :
                       r_to_vector ? (cp0_ebase + EXC_OFFSET) : cp0_epc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed cases with literal expectations plus a
// randomized run checked every cycle against a cycle-scheduled reference model.
`timescale 1ns/1ps
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_syscall, mem_eret, mem_in_ds;
  logic [31:0] mem_pc;
  logic [5:0]  int_i;
  logic [31:0] cp0_ebase, cp0_status, cp0_epc;
  logic        cp0_we, busy, flush, redir_valid;
  logic [2:0]  cp0_type;
  logic [31:0] cp0_excaddr, redir_pc;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_pc      (mem_pc),
    .mem_syscall (mem_syscall),
    .mem_eret    (mem_eret),
    .mem_in_ds   (mem_in_ds),
    .int_i       (int_i),
    .cp0_ebase   (cp0_ebase),
    .cp0_status  (cp0_status),
    .cp0_epc     (cp0_epc),
    .cp0_we      (cp0_we),
    .cp0_type    (cp0_type),
    .cp0_excaddr (cp0_excaddr),
    .busy        (busy),
    .flush       (flush),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted event in cycle A yields cp0_we in A+1 and the
  // redirect in A+2; a new event can only be accepted from A+3 onwards.
  int          cyc      = 0;
  int          last_acc = -100;
  logic [2:0]  m_type   = 3'b000;
  logic [31:0] m_addr   = 32'h0;
  logic        m_vec    = 1'b0;
`ifdef EXC_CTRL_INT_EN
  logic [5:0]  h1 = '0, h2 = '0;
`endif

  task automatic sample();
    logic        ev_int, ev, in_we, in_flush;
    logic [31:0] exp_redir;
    #2;
    if (rst) begin
      last_acc = -100;
      m_type   = 3'b000;
      m_addr   = 32'h0;
      m_vec    = 1'b0;
`ifdef EXC_CTRL_INT_EN
      h1 = '0;
      h2 = '0;
`endif
    end
    ev_int = 1'b0;
`ifdef EXC_CTRL_INT_EN
    ev_int = ((h2 & cp0_status[15:10]) != 6'd0) && cp0_status[0] && !cp0_status[1];
`endif
    ev        = mem_valid && (ev_int || mem_syscall || mem_eret);
    in_we     = (cyc == last_acc + 1);
    in_flush  = (cyc == last_acc + 2);
    exp_redir = !in_flush ? 32'h0 : (m_vec ? cp0_ebase + 32'h180 : cp0_epc);

    check("m_cp0_we",   {31'b0, cp0_we},      {31'b0, in_we});
    check("m_flush",    {31'b0, flush},       {31'b0, in_flush});
    check("m_redir_v",  {31'b0, redir_valid}, {31'b0, in_flush});
    check("m_redir_pc", redir_pc,             exp_redir);
    check("m_busy",     {31'b0, busy},        {31'b0, in_we || in_flush || (ev && cyc >= last_acc + 3)});
    check("m_type",     {29'b0, cp0_type},    {29'b0, m_type});
    check("m_excaddr",  cp0_excaddr,          m_addr);

    if (!rst && ev && cyc >= last_acc + 3) begin
      last_acc = cyc;
      if (ev_int || mem_syscall) begin
        m_type = ev_int ? (mem_in_ds ? 3'b111 : 3'b110) : (mem_in_ds ? 3'b101 : 3'b100);
        m_addr = mem_in_ds ? mem_pc - 32'd4 : mem_pc;
        m_vec  = 1'b1;
      end else begin
        m_type = 3'b010;
        m_addr = 32'h0;
        m_vec  = 1'b0;
      end
    end
`ifdef EXC_CTRL_INT_EN
    h2 = h1;
    h1 = rst ? 6'd0 : int_i;
`endif
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_valid   = 1'b0;
    mem_syscall = 1'b0;
    mem_eret    = 1'b0;
    mem_in_ds   = 1'b0;
    int_i       = 6'd0;
  endtask

  // One event through the whole sequence with literal expectations.
  task automatic run_event(input string name, input logic sys, input logic eret,
                           input logic [31:0] pc, input logic ds,
                           input logic [2:0] exp_type, input logic [31:0] exp_addr,
                           input logic [31:0] exp_redir);
    mem_valid = 1'b1; mem_syscall = sys; mem_eret = eret; mem_pc = pc; mem_in_ds = ds;
    sample();
    check({name, "_busy0"}, {31'b0, busy}, 32'd1);
    tick();
    clr();
    sample();
    check({name, "_we"},   {31'b0, cp0_we},   32'd1);
    check({name, "_type"}, {29'b0, cp0_type}, {29'b0, exp_type});
    check({name, "_addr"}, cp0_excaddr,       exp_addr);
    tick();
    sample();
    check({name, "_flush"}, {31'b0, flush}, 32'd1);
    check({name, "_rpc"},   redir_pc,       exp_redir);
    tick();
    sample();
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clr();
    mem_pc = 32'h0; cp0_ebase = 32'h0; cp0_status = 32'h0; cp0_epc = 32'h0;
    #1;
    sample();
    check("rst_we",   {31'b0, cp0_we},   32'd0);
    check("rst_type", {29'b0, cp0_type}, 32'd0);
    tick();
    sample();
    tick();
    rst = 1'b0;
    sample();
    tick();

    cp0_ebase = 32'h8000_0000;
    cp0_epc   = 32'h0000_1004;
    run_event("sys",    1'b1, 1'b0, 32'h0000_1000, 1'b0, 3'b100, 32'h0000_1000, 32'h8000_0180);
    run_event("sys_ds", 1'b1, 1'b0, 32'h0000_2004, 1'b1, 3'b101, 32'h0000_2000, 32'h8000_0180);
    run_event("eret",   1'b0, 1'b1, 32'h0000_3000, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_1004);
    run_event("both",   1'b1, 1'b1, 32'h0000_1000, 1'b0, 3'b100, 32'h0000_1000, 32'h8000_0180);
    cp0_ebase = 32'hFFFF_FF00;
    run_event("wrap",   1'b1, 1'b0, 32'h0000_0000, 1'b1, 3'b101, 32'hFFFF_FFFC, 32'h0000_0080);

    // Syscall held through COMMIT must not produce a second commit.
    mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h0000_4000;
    sample(); tick();
    sample(); check("hold_we1", {31'b0, cp0_we}, 32'd1); tick();
    clr();
    sample(); check("hold_we2", {31'b0, cp0_we}, 32'd0); tick();
    sample(); check("hold_we3", {31'b0, cp0_we}, 32'd0); tick();

    // Masked by mem_valid=0.
    mem_syscall = 1'b1;
    sample(); check("mask_busy", {31'b0, busy}, 32'd0); tick();
    clr();
    sample(); check("mask_we", {31'b0, cp0_we}, 32'd0); tick();

    // Reset in the middle of COMMIT aborts the sequence.
    mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h0000_5000;
    sample(); tick();
    clr();
    rst = 1'b1;
    sample();
    check("rmid_we",    {31'b0, cp0_we},   32'd0);
    check("rmid_busy",  {31'b0, busy},     32'd0);
    check("rmid_type",  {29'b0, cp0_type}, 32'd0);
    check("rmid_addr",  cp0_excaddr,       32'd0);
    tick();
    rst = 1'b0;
    sample(); check("rmid_we2", {31'b0, cp0_we}, 32'd0); tick();
    sample(); check("rmid_flush", {31'b0, flush}, 32'd0); tick();

`ifdef EXC_CTRL_INT_EN
    cp0_ebase = 32'h8000_0000; cp0_status = 32'h0000_1001;
    mem_valid = 1'b1; mem_pc = 32'h0000_3000; int_i = 6'b000100;
    sample(); check("int_c0", {31'b0, busy}, 32'd0); tick();
    sample(); check("int_c1", {31'b0, busy}, 32'd0); tick();
    sample(); check("int_c2", {31'b0, busy}, 32'd1); tick();
    clr();
    sample();
    check("int_we",   {31'b0, cp0_we},   32'd1);
    check("int_type", {29'b0, cp0_type}, 32'd6);
    check("int_addr", cp0_excaddr,       32'h0000_3000);
    tick();
    sample(); check("int_rpc", redir_pc, 32'h8000_0180); tick();
    cp0_status = 32'h0000_1003;
    mem_valid = 1'b1; int_i = 6'b000100;
    for (int i = 0; i < 6; i++) begin
      sample(); check("int_exl_we", {31'b0, cp0_we}, 32'd0); tick();
    end
    clr();
    cp0_status = 32'h0;
    for (int i = 0; i < 3; i++) begin
      sample(); tick();
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        clr();
        rst = 1'b1;
        sample(); tick();
        rst = 1'b0;
      end else begin
        mem_valid   = ($urandom_range(0, 9) < 7);
        mem_syscall = ($urandom_range(0, 3) == 0);
        mem_eret    = ($urandom_range(0, 3) == 0);
        mem_in_ds   = $urandom_range(0, 1) == 1;
        mem_pc      = $urandom() & 32'hFFFF_FFFC;
        cp0_ebase   = $urandom() & 32'hFFFF_F000;
        cp0_epc     = $urandom();
        case ($urandom_range(0, 3))
          0:       cp0_status = 32'h0000_1001;
          1:       cp0_status = 32'h0000_1003;
          2:       cp0_status = 32'h0000_FC01;
          default: cp0_status = $urandom();
        endcase
        int_i = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : 6'd0;
        sample(); tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
